// File: rtl/mac_unit_acc.sv
// rtl/mac_unit_acc.sv - CMAC MAC cell: LANES-wide dot product, PIPE-cycle latency, optional atom accumulation.
// Optional macro MAC_UNIT_ACC_SAT_EN: saturating accumulator plus mac_out_sat flag.
module mac_unit_acc #(
  parameter int LANES   = 8,
  parameter int DW      = 8,
  parameter int PIPE    = 3,
  parameter int ACC_EXT = 4,
  localparam int OW     = 2*DW + $clog2(LANES) + ACC_EXT
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rstn,
  input  logic                cfg_reg_en,
  input  logic                cfg_is_signed,
  input  logic                cfg_acc_mode,
  input  logic [LANES*DW-1:0] dat_actv_data,
  input  logic [LANES-1:0]    dat_actv_nz,
  input  logic [LANES-1:0]    dat_actv_pvld,
  input  logic [LANES*DW-1:0] wt_actv_data,
  input  logic [LANES-1:0]    wt_actv_nz,
  input  logic [LANES-1:0]    wt_actv_pvld,
  input  logic                dat_actv_last,
  output logic [OW-1:0]       mac_out_data,
  output logic                mac_out_pvld
`ifdef MAC_UNIT_ACC_SAT_EN
  ,
  output logic                mac_out_sat
`endif
);

  logic          cfg_signed;
  logic          cfg_acc;
  logic          atom_vld;
  logic [OW-1:0] atom_sum;
  logic          f_vld;
  logic          f_last;
  logic [OW-1:0] f_sum;
  logic [OW-1:0] acc;
  logic          group_open;
  logic [OW-1:0] base;
  logic [OW-1:0] add_res;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      cfg_signed <= 1'b0;
      cfg_acc    <= 1'b0;
    end else if (cfg_reg_en) begin
      cfg_signed <= cfg_is_signed;
      cfg_acc    <= cfg_acc_mode;
    end
  end

  // Operands are extended straight to OW bits; the low OW bits of the product are exact.
  always_comb begin
    logic [DW-1:0] d;
    logic [DW-1:0] w;
    logic [OW-1:0] d_ext;
    logic [OW-1:0] w_ext;
    d        = '0;
    w        = '0;
    d_ext    = '0;
    w_ext    = '0;
    atom_vld = dat_actv_pvld[0] & wt_actv_pvld[0];
    atom_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      d     = dat_actv_data[i*DW +: DW];
      w     = wt_actv_data[i*DW +: DW];
      d_ext = {{(OW-DW){cfg_signed & d[DW-1]}}, d};
      w_ext = {{(OW-DW){cfg_signed & w[DW-1]}}, w};
      if (dat_actv_pvld[i] & wt_actv_pvld[i] & dat_actv_nz[i] & wt_actv_nz[i])
        atom_sum = atom_sum + d_ext * w_ext;
    end
  end

  generate
    if (PIPE > 1) begin : g_pipe
      logic [OW-1:0] p_sum [PIPE-1];
      logic [PIPE-2:0] p_vld;
      logic [PIPE-2:0] p_last;

      always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
          p_vld  <= '0;
          p_last <= '0;
          for (int s = 0; s < PIPE-1; s++) p_sum[s] <= '0;
        end else begin
          p_vld[0]  <= atom_vld;
          p_last[0] <= atom_vld & dat_actv_last;
          if (atom_vld) p_sum[0] <= atom_sum;
          for (int s = 1; s < PIPE-1; s++) begin
            p_vld[s]  <= p_vld[s-1];
            p_last[s] <= p_last[s-1];
            if (p_vld[s-1]) p_sum[s] <= p_sum[s-1];
          end
        end
      end

      assign f_vld  = p_vld[PIPE-2];
      assign f_last = p_last[PIPE-2];
      assign f_sum  = p_sum[PIPE-2];
    end else begin : g_nopipe
      assign f_vld  = atom_vld;
      assign f_last = atom_vld & dat_actv_last;
      assign f_sum  = atom_sum;
    end
  endgenerate

`ifdef MAC_UNIT_ACC_SAT_EN
  logic [OW:0] wide;
  logic        ovf;
  logic        sat_grp;
`endif

  always_comb begin
    base = (cfg_acc & group_open) ? acc : '0;
`ifdef MAC_UNIT_ACC_SAT_EN
    wide = {1'b0, base} + {1'b0, f_sum};
    if (cfg_signed) begin
      ovf     = (base[OW-1] == f_sum[OW-1]) && (wide[OW-1] != base[OW-1]);
      add_res = base[OW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end else begin
      ovf     = wide[OW];
      add_res = '1;
    end
    if (!ovf) add_res = wide[OW-1:0];
`else
    add_res = base + f_sum;
`endif
  end

  // A cfg write discards any open group; non-accumulating atoms already in flight still report.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      acc          <= '0;
      group_open   <= 1'b0;
      mac_out_data <= '0;
      mac_out_pvld <= 1'b0;
`ifdef MAC_UNIT_ACC_SAT_EN
      sat_grp      <= 1'b0;
      mac_out_sat  <= 1'b0;
`endif
    end else begin
      mac_out_pvld <= 1'b0;
      if (f_vld && !cfg_acc) begin
        mac_out_data <= add_res;
        mac_out_pvld <= 1'b1;
`ifdef MAC_UNIT_ACC_SAT_EN
        mac_out_sat  <= ovf;
`endif
      end
      if (cfg_reg_en) begin
        acc        <= '0;
        group_open <= 1'b0;
`ifdef MAC_UNIT_ACC_SAT_EN
        sat_grp    <= 1'b0;
`endif
      end else if (f_vld && cfg_acc) begin
        if (f_last) begin
          mac_out_data <= add_res;
          mac_out_pvld <= 1'b1;
          acc          <= '0;
          group_open   <= 1'b0;
`ifdef MAC_UNIT_ACC_SAT_EN
          mac_out_sat  <= sat_grp | ovf;
          sat_grp      <= 1'b0;
`endif
        end else begin
          acc        <= add_res;
          group_open <= 1'b1;
`ifdef MAC_UNIT_ACC_SAT_EN
          sat_grp    <= sat_grp | ovf;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_unit_acc.sv
// tb/tb_mac_unit_acc.sv - directed self-checking bench for mac_unit_acc.
module tb_mac_unit_acc;
  localparam int LANES = 8;
  localparam int DW    = 8;
  localparam int OW    = 23;

  logic                nvdla_core_clk = 1'b0;
  logic                nvdla_core_rstn = 1'b0;
  logic                cfg_reg_en = 1'b0;
  logic                cfg_is_signed = 1'b0;
  logic                cfg_acc_mode = 1'b0;
  logic [LANES*DW-1:0] dat_actv_data = '0;
  logic [LANES-1:0]    dat_actv_nz = '0;
  logic [LANES-1:0]    dat_actv_pvld = '0;
  logic [LANES*DW-1:0] wt_actv_data = '0;
  logic [LANES-1:0]    wt_actv_nz = '0;
  logic [LANES-1:0]    wt_actv_pvld = '0;
  logic                dat_actv_last = 1'b0;
  logic [OW-1:0]       mac_out_data;
  logic                mac_out_pvld;
`ifdef MAC_UNIT_ACC_SAT_EN
  logic                mac_out_sat;
`endif

  mac_unit_acc dut (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rstn(nvdla_core_rstn),
    .cfg_reg_en     (cfg_reg_en),
    .cfg_is_signed  (cfg_is_signed),
    .cfg_acc_mode   (cfg_acc_mode),
    .dat_actv_data  (dat_actv_data),
    .dat_actv_nz    (dat_actv_nz),
    .dat_actv_pvld  (dat_actv_pvld),
    .wt_actv_data   (wt_actv_data),
    .wt_actv_nz     (wt_actv_nz),
    .wt_actv_pvld   (wt_actv_pvld),
    .dat_actv_last  (dat_actv_last),
    .mac_out_data   (mac_out_data),
    .mac_out_pvld   (mac_out_pvld)
`ifdef MAC_UNIT_ACC_SAT_EN
    ,
    .mac_out_sat    (mac_out_sat)
`endif
  );

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  int cyc = 0;
  always @(posedge nvdla_core_clk) cyc <= cyc + 1;

  logic [OW-1:0] q_d[$];
  int            q_c[$];
  logic          q_s[$];

  always @(negedge nvdla_core_clk) begin
    if (mac_out_pvld) begin
      q_d.push_back(mac_out_data);
      q_c.push_back(cyc);
`ifdef MAC_UNIT_ACC_SAT_EN
      q_s.push_back(mac_out_sat);
`else
      q_s.push_back(1'b0);
`endif
    end
  end

  int n_chk = 0;
  int n_pass = 0;
  int t_drv = 0;
  int t_first = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [OW-1:0] qd(input int i);
    return (q_d.size() > i) ? q_d[i] : '1;
  endfunction

  function automatic int qc(input int i);
    return (q_c.size() > i) ? q_c[i] : -1000;
  endfunction

  function automatic logic qs(input int i);
    return (q_s.size() > i) ? q_s[i] : 1'bx;
  endfunction

  task automatic idle();
    dat_actv_pvld = '0;
    wt_actv_pvld  = '0;
    dat_actv_last = 1'b0;
  endtask

  task automatic clr();
    q_d.delete();
    q_c.delete();
    q_s.delete();
  endtask

  task automatic settle();
    idle();
    repeat (6) @(negedge nvdla_core_clk);
  endtask

  task automatic set_cfg(input logic s, input logic a);
    cfg_is_signed = s;
    cfg_acc_mode  = a;
    cfg_reg_en    = 1'b1;
    @(negedge nvdla_core_clk);
    cfg_reg_en    = 1'b0;
  endtask

  task automatic atom(input logic [7:0] d, input logic [7:0] w, input logic [7:0] dnz,
                      input logic [7:0] wpv, input logic last);
    dat_actv_data = {8{d}};
    wt_actv_data  = {8{w}};
    dat_actv_nz   = dnz;
    wt_actv_nz    = '1;
    dat_actv_pvld = '1;
    wt_actv_pvld  = wpv;
    dat_actv_last = last;
    t_drv = cyc;
    @(negedge nvdla_core_clk);
  endtask

  initial begin
    repeat (3) @(negedge nvdla_core_clk);
    check("rst_pvld", mac_out_pvld, 1'b0);
    check("rst_data", mac_out_data, 0);
    nvdla_core_rstn = 1'b1;
    @(negedge nvdla_core_clk);

    // signed, all lanes 3 * -2
    set_cfg(1'b1, 1'b0);
    clr();
    atom(8'hFE, 8'd3, 8'hFF, 8'hFF, 1'b0);
    settle();
    check("s8_cnt", q_d.size(), 1);
    check("s8_data", qd(0), 23'h7FFFD0);
    check("s8_lat", qc(0) - t_drv, 3);

    // lane 3 nz off, lane 5 weight pvld off
    clr();
    atom(8'hFE, 8'd3, 8'hF7, 8'hDF, 1'b0);
    settle();
    check("gate_cnt", q_d.size(), 1);
    check("gate_data", qd(0), 23'h7FFFDC);
    check("gate_hold", mac_out_data, 23'h7FFFDC);

    // unsigned max, back-to-back
    set_cfg(1'b0, 1'b0);
    clr();
    t_first = cyc;
    for (int i = 0; i < 4; i++) atom(8'd255, 8'd255, 8'hFF, 8'hFF, 1'b0);
    settle();
    check("b2b_cnt", q_d.size(), 4);
    check("b2b_lat", qc(0) - t_first, 3);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b2b_data%0d", i), qd(i), 520200);
      check($sformatf("b2b_cyc%0d", i), qc(i) - qc(0), i);
    end

    // unsigned accumulation, 4 x 10 then 1 x 7
    set_cfg(1'b0, 1'b1);
    clr();
    for (int i = 0; i < 4; i++) atom(8'd5, 8'd2, 8'h01, 8'hFF, i == 3);
    settle();
    check("acc_cnt", q_d.size(), 1);
    check("acc_data", qd(0), 40);
    check("acc_lat", qc(0) - t_drv, 3);
`ifdef MAC_UNIT_ACC_SAT_EN
    check("acc_nosat", qs(0), 1'b0);
`endif
    clr();
    atom(8'd7, 8'd1, 8'h01, 8'hFF, 1'b1);
    settle();
    check("one_cnt", q_d.size(), 1);
    check("one_data", qd(0), 7);

    // 17 atoms of 520200 overflow the 23-bit accumulator
    clr();
    for (int i = 0; i < 17; i++) atom(8'd255, 8'd255, 8'hFF, 8'hFF, i == 16);
    settle();
    check("ovf_cnt", q_d.size(), 1);
`ifdef MAC_UNIT_ACC_SAT_EN
    check("ovf_data", qd(0), 8388607);
    check("ovf_sat", qs(0), 1'b1);
`else
    check("ovf_data", qd(0), 454792);
`endif

    // reset in the middle of an open group
    clr();
    for (int i = 0; i < 2; i++) atom(8'd5, 8'd2, 8'h01, 8'hFF, 1'b0);
    idle();
    repeat (4) @(negedge nvdla_core_clk);
    nvdla_core_rstn = 1'b0;
    #1;
    check("mrst_pvld", mac_out_pvld, 1'b0);
    check("mrst_data", mac_out_data, 0);
    @(negedge nvdla_core_clk);
    nvdla_core_rstn = 1'b1;
    @(negedge nvdla_core_clk);
    set_cfg(1'b0, 1'b1);
    atom(8'd5, 8'd1, 8'h01, 8'hFF, 1'b1);
    settle();
    check("post_cnt", q_d.size(), 1);
    check("post_data", qd(0), 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mac_unit_acc.md
Name: mac_unit_acc

Overview:
- Parametrised next-generation CMAC MAC cell: LANES-wide signed/unsigned dot product with a configurable pipeline depth and an optional in-cell accumulator across atoms.
- Products are gated per lane by nz and pvld.
- Sits in cmac between the active-data/weight registers and the CACC output path.
- Drop-in superset of the fixed 8-lane MAC cell when LANES=8, PIPE=3, accumulation off.

Parameters:
- LANES, 8, number of multiplier lanes (power of 2, 2..64)
- DW, 8, element width per lane for data and weight
- PIPE, 3, total latency in cycles from input to output (>=1); last stage is the output/accumulate register
- ACC_EXT, 4, extra accumulator guard bits
- OW, 2*DW+$clog2(LANES)+ACC_EXT, output width (derived; do not override)

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  asynchronous active-low reset
- cfg_reg_en  in  1  latches cfg_is_signed and cfg_acc_mode this cycle
- cfg_is_signed  in  1  1 = two's-complement operands, 0 = unsigned
- cfg_acc_mode  in  1  1 = accumulate atoms until last, 0 = one output per atom
- dat_actv_data  in  LANES*DW  data lanes, lane i at [i*DW +: DW]
- dat_actv_nz  in  LANES  data non-zero flags
- dat_actv_pvld  in  LANES  data lane valids
- wt_actv_data  in  LANES*DW  weight lanes
- wt_actv_nz  in  LANES  weight non-zero flags
- wt_actv_pvld  in  LANES  weight lane valids
- dat_actv_last  in  1  final atom of an accumulation group (sampled with atom valid)
- mac_out_data  out  OW  result; sign-extended if signed, zero-extended if unsigned
- mac_out_pvld  out  1  result valid, single-cycle pulse per result

Behaviour:
- Single clock nvdla_core_clk; asynchronous active-low reset nvdla_core_rstn.
- Reset clears all pipeline data, valids, accumulator and latched cfg (signed=0, acc_mode=0); mac_out_data=0, mac_out_pvld=0.
- Atom valid = dat_actv_pvld[0] & wt_actv_pvld[0].
- Lane enable i = dat_actv_pvld[i] & wt_actv_pvld[i] & dat_actv_nz[i] & wt_actv_nz[i]; a disabled lane contributes exactly 0.
- Products: operands extended to DW+1 bits (sign or zero per latched cfg_is_signed); product 2*DW+2 bits. Sum is extended to OW and added with no truncation.
- Pipeline: stages 1..PIPE-1 carry sum plus valid/last; data registers load only when their valid is set (hold otherwise); valid registers always update.
- Non-acc mode: final stage registers the sum; mac_out_pvld=1 exactly PIPE cycles after a valid atom, and once per atom. Back-to-back atoms give back-to-back outputs.
- Acc mode, final stage: acc <= (group_open ? acc : 0) + sum.
  - group_open is set by a valid atom without last.
  - group_open is cleared by a valid atom with last.
  - mac_out_pvld=1 only on the cycle the last atom's sum is absorbed (PIPE cycles after the last atom); mac_out_data=final acc.
  - A last on the first atom gives a one-atom group.
- mac_out_data holds its value between pvld pulses.
- Overflow with the macro absent: the accumulator wraps modulo 2^OW.
- cfg_reg_en while the pipeline holds valid atoms: the new cfg applies to atoms entering from the next cycle; any open group is discarded (acc cleared, group_open=0, no pvld).
- Reset asserted mid-group: the group is discarded; the first atom after reset starts a new group from 0.
- Lanes >0 with pvld=0 while lane 0 is valid are treated as zero contribution, not an error.

Optional Feature:
- Macro: MAC_UNIT_ACC_SAT_EN.
- Defined:
  - The accumulator add saturates to the OW-bit range: signed [-2^(OW-1), 2^(OW-1)-1]; unsigned [0, 2^OW-1].
  - Adds output mac_out_sat (1 bit), valid with mac_out_pvld; set if any add in the reported group (or atom) saturated.
  - mac_out_sat resets to 0.
- Undefined: wrap-around arithmetic; no mac_out_sat port.

Test Plan:
- Defaults, signed, acc off; all 8 lanes wt=3, dat=-2, nz=1, pvld=1 for one cycle -> 3 cycles later mac_out_pvld=1 for 1 cycle, mac_out_data=-48 (23-bit sign-extended).
- Same stimulus with dat_actv_nz[3]=0 and wt_actv_pvld[5]=0 -> mac_out_data=-36.
- Unsigned, all lanes 255x255 -> mac_out_data=520200; back-to-back 4 atoms -> 4 consecutive pvld cycles.
- Acc on, 4 atoms each summing 10, last on the 4th -> exactly one pvld, data=40, 3 cycles after the 4th atom; next group of 1 atom summing 7 with last -> 7.
- Unsigned acc, 17 atoms of 520200 -> MAC_UNIT_ACC_SAT_EN defined: data=8388607, mac_out_sat=1; undefined: data=454792.
- Acc on, 2 atoms, then nvdla_core_rstn low for 1 cycle -> outputs 0 immediately; after release, 1 atom summing 5 with last -> data=5.
